// File: rtl/mem_access_unit.sv
// Sequences one 16-bit load/store into one or two byte transfers on a req/ack data bus.
// Latency: byte op done 2 cycles after start, word op 3, NOP/illegal/misaligned 1 (immediate acks).
// Backpressure: busy stalls the pipeline while a transfer waits on mem_ack; the wait is bounded by TIMEOUT.
module mem_access_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mem_w,
    input  logic              mbyte,
    input  logic              down,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, XFER0, XFER1, FIN} state_t;

    typedef struct packed {
        logic load;
        logic store;
        logic word;
        logic err;
    } cmd_t;

    localparam logic [16:0]       TMO_LIM  = 17'(TIMEOUT);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       tmo_cnt_q;
    logic [7:0]        hi_dat_q;
    logic              dec_illegal, dec_nop, dec_word, go_xfer;
    logic              in_xfer, last_ack, tmo_hit;

    always_comb begin
        cmd_d       = '0;
        dec_illegal = (mem_w == 2'b11) || (down && (mem_w != 2'b00));
        dec_nop     = !down && (mem_w == 2'b00);
        dec_word    = down ? !mbyte : (mem_w == 2'b10);
        cmd_d.load  = down && !dec_illegal;
        cmd_d.store = !down && !dec_illegal && !dec_nop;
        cmd_d.word  = dec_word;
        // Words must be even-aligned; odd addresses never reach the bus.
        cmd_d.err   = dec_illegal || (!dec_nop && dec_word && addr[0]);
        go_xfer     = !dec_nop && !cmd_d.err;
    end

    assign in_xfer  = (state_q == XFER0) || (state_q == XFER1);
    assign tmo_hit  = ({1'b0, tmo_cnt_q} + 17'd1) == TMO_LIM;
    assign last_ack = mem_ack && ((state_q == XFER1) || ((state_q == XFER0) && !cmd_q.word));

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = go_xfer ? XFER0 : FIN;
            end
            XFER0: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = cmd_q.store;
                mem_addr  = addr_q;
                // Big-endian: the first transfer of a word carries the high byte.
                mem_wdata = cmd_q.word ? wdata_q[15:8] : wdata_q[7:0];
                if (mem_ack)      state_d = cmd_q.word ? XFER1 : FIN;
                else if (tmo_hit) state_d = FIN;
            end
            XFER1: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = cmd_q.store;
                mem_addr  = addr_q + ADDR_ONE;
                mem_wdata = wdata_q[7:0];
                if (mem_ack || tmo_hit) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                err     = cmd_q.err;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tmo_cnt_q <= '0;
            hi_dat_q  <= '0;
            rdata     <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && start) begin
                cmd_q   <= cmd_d;
                addr_q  <= addr;
                wdata_q <= wdata;
            end else if (in_xfer && !mem_ack && tmo_hit) begin
                cmd_q.err <= 1'b1;
            end
            // Counter restarts on every state change, so each byte gets a full window.
            if (state_d != state_q) tmo_cnt_q <= '0;
            else if (in_xfer)       tmo_cnt_q <= tmo_cnt_q + 16'd1;
            if ((state_q == XFER0) && mem_ack) hi_dat_q <= mem_rdata;
            if (last_ack && cmd_q.load)
                rdata <= cmd_q.word ? {hi_dat_q, mem_rdata} : {{8{mem_rdata[7]}}, mem_rdata};
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-built corner sequences, and random ops against a byte-memory model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst, start, mbyte, down;
    logic [1:0]  mem_w;
    logic [15:0] addr, wdata, rdata, mem_addr;
    logic        busy, done, err, mem_req, mem_we, mem_ack;
    logic [7:0]  mem_wdata, mem_rdata;

    mem_access_unit #(.ADDR_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_w(mem_w), .mbyte(mbyte), .down(down),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
    } xfer_t;

    typedef struct {
        logic [1:0]  mw;
        logic        mb;
        logic        dn;
        logic [15:0] a;
        logic [15:0] wd;
        int          d;
        bit          en;
        int          e_done;
        bit          e_err;
        int          e_req;
        logic [15:0] e_rd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  bmem [0:65535];
    logic [7:0]  rmem [0:65535];
    xfer_t       log_q [$];
    xfer_t       exp_q [$];
    logic [15:0] exp_rdata;
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    vec_t        tv [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Byte-wide memory responder: acks after ack_delay waiting cycles, random junk on mem_rdata otherwise.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            mem_rdata = 8'($urandom);
            if (mem_req && ack_en && !rst) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bmem[mem_addr];
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    log_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : 8'h00});
                end else begin
                    wait_cnt++;
                end
            end else if (!mem_req) begin
                wait_cnt = 0;
            end
        end
    end

    // Reference: what a command should do, from the command rules and memory contents alone.
    task automatic model_op(input logic [1:0] mw, input logic mb, input logic dn, input logic [15:0] a,
                            input logic [15:0] wd, input int d, input bit en,
                            output int e_done, output bit e_err, output int e_req);
        bit illegal, nop, word;
        int n;
        logic [15:0] ba;
        logic [7:0]  bv;
        exp_q.delete();
        illegal = (mw == 2'b11) || (dn && mw != 2'b00);
        nop     = !dn && mw == 2'b00;
        word    = dn ? !mb : (mw == 2'b10);
        e_done = 1; e_err = 1'b0; e_req = 0;
        if (illegal || (!nop && word && a[0])) begin
            e_err = 1'b1;
            return;
        end
        if (nop) return;
        n = word ? 2 : 1;
        if (!en || d >= TMO) begin
            e_req = TMO; e_done = TMO + 1; e_err = 1'b1;
            return;
        end
        e_req  = n * (d + 1);
        e_done = e_req + 1;
        for (int i = 0; i < n; i++) begin
            ba = a + 16'(i);
            if (dn) begin
                exp_q.push_back('{1'b0, ba, 8'h00});
            end else begin
                bv = (word && i == 0) ? wd[15:8] : wd[7:0];
                exp_q.push_back('{1'b1, ba, bv});
                rmem[ba] = bv;
            end
        end
        if (dn) exp_rdata = word ? {rmem[a], rmem[a + 16'd1]} : {{8{rmem[a][7]}}, rmem[a]};
    endtask

    task automatic run_op(input string tag, input logic [1:0] mw, input logic mb, input logic dn,
                          input logic [15:0] a, input logic [15:0] wd, input int d, input bit en,
                          input int restart_cyc, output int done_cyc, output bit o_err,
                          output int req_n, output int busy_n, output logic [15:0] rd);
        ack_delay = d;
        ack_en    = en;
        log_q.delete();
        done_cyc = -1; o_err = 1'b0; req_n = 0; busy_n = 0; rd = 16'h0;
        @(posedge clk); #1;
        mem_w = mw; mbyte = mb; down = dn; addr = a; wdata = wd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mem_w = 2'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == restart_cyc) begin
                start = 1'b1; mem_w = 2'b01; down = 1'b0; addr = 16'h0033; wdata = 16'h00C3;
            end else if (c == restart_cyc + 1) begin
                start = 1'b0;
            end
            if (mem_req) req_n++;
            if (busy) busy_n++;
            if (done) begin
                done_cyc = c; o_err = err; rd = rdata;
                break;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL %s no done within budget", tag);
        end else begin
            @(negedge clk);
            chk({tag, " idle-after"}, {29'd0, done, mem_req, busy}, 32'd0);
        end
    endtask

    task automatic check_xfers(input string tag);
        chk({tag, " nxfer"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk({tag, " xfer"}, {7'd0, log_q[i].we, log_q[i].a, log_q[i].d},
                {7'd0, exp_q[i].we, exp_q[i].a, exp_q[i].d});
    endtask

    initial begin
        int dc, rq, bz, e_done, e_req, n_quiet;
        bit oe, e_err;
        logic [15:0] rd, a;
        logic [1:0] mw;
        logic mb, dn;
        int kind, d;
        bit en;
        logic [7:0] v;

        //        mw     mb    dn    addr      wdata     dly en  done err req rdata
        tv[0]  = '{2'b00, 1'b0, 1'b1, 16'h0040, 16'h0000, 0, 1, 3, 0, 2, 16'h1234};
        tv[1]  = '{2'b10, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 3, 1, 9, 0, 8, 16'h1234};
        tv[2]  = '{2'b00, 1'b1, 1'b1, 16'h0005, 16'h0000, 0, 1, 2, 0, 1, 16'hFF80};
        tv[3]  = '{2'b01, 1'b0, 1'b0, 16'h0005, 16'h00AA, 0, 1, 2, 0, 1, 16'hFF80};
        tv[4]  = '{2'b00, 1'b0, 1'b1, 16'h0003, 16'h0000, 0, 1, 1, 1, 0, 16'hFF80};
        tv[5]  = '{2'b10, 1'b0, 1'b1, 16'h0020, 16'h0000, 0, 1, 1, 1, 0, 16'hFF80};
        tv[6]  = '{2'b00, 1'b0, 1'b0, 16'h0020, 16'h1111, 0, 1, 1, 0, 0, 16'hFF80};
        tv[7]  = '{2'b11, 1'b0, 1'b0, 16'h0020, 16'h2222, 0, 1, 1, 1, 0, 16'hFF80};
        tv[8]  = '{2'b00, 1'b1, 1'b1, 16'h0041, 16'h0000, 2, 1, 4, 0, 3, 16'h0034};
        tv[9]  = '{2'b00, 1'b0, 1'b1, 16'h0010, 16'h0000, 1, 1, 5, 0, 4, 16'hBEEF};
        tv[10] = '{2'b00, 1'b1, 1'b1, 16'h0005, 16'h0000, 0, 1, 2, 0, 1, 16'hFFAA};
        tv[11] = '{2'b01, 1'b0, 1'b0, 16'h0007, 16'h1280, 5, 1, 5, 1, 4, 16'hFFAA};

        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            bmem[i] = v;
            rmem[i] = v;
        end
        bmem[16'h0040] = 8'h12; rmem[16'h0040] = 8'h12;
        bmem[16'h0041] = 8'h34; rmem[16'h0041] = 8'h34;
        bmem[16'h0005] = 8'h80; rmem[16'h0005] = 8'h80;
        exp_rdata = 16'h0000;

        rst = 1'b1; start = 1'b0; mem_w = 2'b00; mbyte = 1'b0; down = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset flags", {27'd0, busy, done, err, mem_req, mem_we}, 32'd0);
        chk("reset rdata", {16'd0, rdata}, 32'd0);
        chk("reset mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            model_op(tv[i].mw, tv[i].mb, tv[i].dn, tv[i].a, tv[i].wd, tv[i].d, tv[i].en, e_done, e_err, e_req);
            run_op($sformatf("vec%0d", i), tv[i].mw, tv[i].mb, tv[i].dn, tv[i].a, tv[i].wd,
                   tv[i].d, tv[i].en, 0, dc, oe, rq, bz, rd);
            chk($sformatf("vec%0d done-cycle", i), dc, tv[i].e_done);
            chk($sformatf("vec%0d err", i), {31'd0, oe}, {31'd0, tv[i].e_err});
            chk($sformatf("vec%0d req-cycles", i), rq, tv[i].e_req);
            chk($sformatf("vec%0d busy-cycles", i), bz, tv[i].e_done - 1);
            chk($sformatf("vec%0d rdata", i), {16'd0, rd}, {16'd0, tv[i].e_rd});
            check_xfers($sformatf("vec%0d", i));
        end

        // Timeout with no ack; a second start lands while busy and must be dropped.
        run_op("tmo", 2'b00, 1'b1, 1'b1, 16'h0040, 16'h0000, 0, 1'b0, 2, dc, oe, rq, bz, rd);
        chk("tmo done-cycle", dc, TMO + 1);
        chk("tmo err", {31'd0, oe}, 32'd1);
        chk("tmo req-cycles", rq, TMO);
        chk("tmo rdata kept", {16'd0, rd}, 32'h0000FFAA);
        n_quiet = 0;
        ack_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_req || done || busy) n_quiet++;
        end
        chk("tmo no extra op", n_quiet, 0);
        chk("tmo no bus xfer", log_q.size(), 0);

        // Reset while the second byte of a word load is outstanding.
        ack_delay = 2; ack_en = 1'b1;
        @(posedge clk); #1;
        mem_w = 2'b00; mbyte = 1'b0; down = 1'b1; addr = 16'h0040; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 4) begin
                chk("rst-x1 req", {31'd0, mem_req}, 32'd1);
                chk("rst-x1 addr", {16'd0, mem_addr}, 32'h00000041);
                chk("rst-x1 busy", {31'd0, busy}, 32'd1);
            end
            if (c == 5) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("rst-x1 after", {29'd0, mem_req, busy, done}, 32'd0);
        chk("rst-x1 rdata", {16'd0, rdata}, 32'd0);
        n_quiet = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || mem_req) n_quiet++;
        end
        chk("rst-x1 no done", n_quiet, 0);
        exp_rdata = 16'h0000;
        model_op(2'b00, 1'b1, 1'b1, 16'h0005, 16'h0000, 0, 1'b1, e_done, e_err, e_req);
        run_op("post-rst lb", 2'b00, 1'b1, 1'b1, 16'h0005, 16'h0000, 0, 1'b1, 0, dc, oe, rq, bz, rd);
        chk("post-rst lb done", dc, e_done);
        chk("post-rst lb rdata", {16'd0, rd}, {16'd0, exp_rdata});
        check_xfers("post-rst lb");

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            mb = 1'($urandom);
            a  = 16'($urandom_range(0, 63));
            case (kind)
                0, 1:    begin dn = 1'b1; mw = 2'b00; mb = 1'b1; end
                2, 3:    begin dn = 1'b1; mw = 2'b00; mb = 1'b0; end
                4, 5:    begin dn = 1'b0; mw = 2'b01; end
                6, 7:    begin dn = 1'b0; mw = 2'b10; end
                8:       begin dn = 1'b0; mw = 2'b00; end
                default: begin dn = 1'($urandom); mw = dn ? 2'($urandom_range(1, 3)) : 2'b11; end
            endcase
            if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
            d  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
            en = ($urandom_range(0, 15) != 0);
            wdata = 16'($urandom);
            model_op(mw, mb, dn, a, wdata, d, en, e_done, e_err, e_req);
            run_op($sformatf("rnd%0d", i), mw, mb, dn, a, wdata, d, en, 0, dc, oe, rq, bz, rd);
            chk($sformatf("rnd%0d done-cycle", i), dc, e_done);
            chk($sformatf("rnd%0d err", i), {31'd0, oe}, {31'd0, e_err});
            chk($sformatf("rnd%0d req-cycles", i), rq, e_req);
            chk($sformatf("rnd%0d busy-cycles", i), bz, e_done - 1);
            chk($sformatf("rnd%0d rdata", i), {16'd0, rd}, {16'd0, exp_rdata});
            check_xfers($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
